tbec_inject_ctrl: RTL

Campaign sequencer for the TBEC/RSC 16→32 encoder with fault injection. It generates a reproducible pseudo-random stream of data words, injection patterns and injection positions, and drives them into the combinational encoder. It captures each encoded, corrupted codeword and writes it to the FPGA-side memory writer over a valid/ready interface, with one address per word. It sits between the host control registers (start/abort/status) and the encoder + memory write path.

---
 rtl/tbec_inject_ctrl_if.sv | 27 ++
 rtl/tbec_inject_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tbec_inject_ctrl_if.sv
// Memory write channel between the injection sequencer and the FPGA-side
// memory writer. A word transfers on a cycle where valid and ready are both high.
interface tbec_inject_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic [7:0]        mem_wr_meta;

    modport master (
        output mem_wr_valid,
        input  mem_wr_ready,
        output mem_wr_addr,
        output mem_wr_data,
        output mem_wr_meta
    );

    modport slave (
        input  mem_wr_valid,
        output mem_wr_ready,
        input  mem_wr_addr,
        input  mem_wr_data,
        input  mem_wr_meta
    );
endinterface

// File: rtl/tbec_inject_ctrl.sv
// Fault-injection campaign sequencer for the TBEC/RSC 16->32 encoder.
// A Galois LFSR supplies data word, injection pattern and injection position.
// Each corrupted codeword is captured and written out, one address per word.
module tbec_inject_ctrl #(
    parameter int          NUM_WORDS = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] LFSR_SEED = 32'h00AB_1234
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              inject_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   inj_count,
    output logic [15:0]       enc_data_in,
    output logic [2:0]        enc_rand_vals,
    output logic [4:0]        enc_rand_pos,
    input  logic [31:0]       enc_data_out,
    tbec_inject_ctrl_if.master mem_wr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [31:0]       r_lfsr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_inj_count;
    logic [31:0]       r_data;
    logic [7:0]        r_meta;
    logic              w_handshake;
    logic              w_last;

    // One right shift of the Galois LFSR; taps fold in when a 1 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] shifted;
        shifted = v >> 1;
        if (v[0]) begin
            return shifted ^ LFSR_TAPS;
        end else begin
            return shifted;
        end
    endfunction

    assign w_handshake = (r_state == S_WRITE) && mem_wr.mem_wr_ready;
    assign w_last      = (r_addr == LAST_ADDR);

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next_state = S_DRIVE;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_DRIVE: w_next_state = S_WRITE;
                S_WRITE: begin
                    if (w_handshake) begin
                        if (w_last) begin
                            w_next_state = S_DONE;
                        end else begin
                            w_next_state = S_DRIVE;
                        end
                    end else begin
                        w_next_state = S_WRITE;
                    end
                end
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Campaign datapath: LFSR, address, injection count and capture registers.
    // An abort freezes everything so the host can read where the campaign stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= LFSR_SEED;
            r_addr      <= '0;
            r_inj_count <= '0;
            r_data      <= 32'h0000_0000;
            r_meta      <= 8'h00;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lfsr      <= LFSR_SEED;
                        r_addr      <= '0;
                        r_inj_count <= '0;
                    end
                end
                S_DRIVE: begin
                    // Encoder has had a full cycle to settle on the LFSR-driven inputs.
                    r_data <= enc_data_out;
                    r_meta <= {enc_rand_vals, enc_rand_pos};
                end
                S_WRITE: begin
                    if (w_handshake) begin
                        if (r_meta[7:5] != 3'b000) begin
                            r_inj_count <= r_inj_count + (ADDR_W+1)'(1);
                        end
                        r_lfsr <= lfsr_step(r_lfsr);
                        if (!w_last) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded straight from registered state and LFSR bits.
    assign busy          = (r_state == S_DRIVE) || (r_state == S_WRITE);
    assign done          = (r_state == S_DONE);
    assign inj_count     = r_inj_count;
    assign enc_data_in   = r_lfsr[15:0];
    assign enc_rand_vals = inject_en ? r_lfsr[18:16] : 3'b000;
    assign enc_rand_pos  = r_lfsr[23:19];

    assign mem_wr.mem_wr_valid = (r_state == S_WRITE);
    assign mem_wr.mem_wr_addr  = r_addr;
    assign mem_wr.mem_wr_data  = r_data;
    assign mem_wr.mem_wr_meta  = r_meta;

endmodule
